bus_reg_responder: RTL
======================

// Module: bus_reg_responder
// PURPOSE
// - Slave end of the VJTAG host system bus. Accepts wvalid/rvalid requests (address, wdata), drives ready,
//   and returns read data on rsp_valid/rsp_data.
// - Implements a bank of NUM_REGS read/write registers, exported flat to system logic.
// - Programmable request wait states and read latency model slow peripherals for host bring-up and test.
// PARAMETERS
// - ADDR_WIDTH    16  bus address width
// - DATA_WIDTH    16  bus data width; width of each register
// - NUM_REGS      16  number of registers; power of 2, >= 2
// - REQ_WAIT      0   cycles valid must be held before ready asserts (0 = same-cycle ready)
// - READ_LATENCY  1   cycles from read accept edge to rsp_valid high; >= 1
// PORTS
// - clk       in   1                    system clock
// - rst_n     in   1                    synchronous active-low reset
// - address   in   ADDR_WIDTH           request address; stable while valid is high
// - wvalid    in   1                    write request
// - rvalid    in   1                    read request
// - wdata     in   DATA_WIDTH           write data
// - ready     out  1                    request accepted this cycle when (wvalid|rvalid)&ready
// - rsp_valid out  1                    one-cycle read response strobe
// - rsp_data  out  DATA_WIDTH           read data, valid with rsp_valid
// - reg_out   out  NUM_REGS*DATA_WIDTH  register bank; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
// BEHAVIOUR
// - Reset, synchronous: FSM=IDLE, wait_cnt=0, lat_cnt=0, rsp_valid=0, rsp_data=0, all regs=0.
// - ready is forced 0 while rst_n=0.
// - FSM states:
//   - IDLE: accepts requests.
//   - RLAT: read in flight; ready=0; any wvalid/rvalid present is held off, not dropped.
// - wait_cnt (IDLE only):
//   - Increments each cycle (wvalid|rvalid)=1 and wait_cnt<REQ_WAIT.
//   - Clears to 0 on accept or when valid drops.
// - ready = (state==IDLE) & (wvalid|rvalid) & (wait_cnt==REQ_WAIT). Combinational; initiator waits on it.
// - idx = address[$clog2(NUM_REGS)-1:0]. mapped = (address < NUM_REGS). Upper address bits are compared, not ignored.
// - Write accept: if mapped, regs[idx] <= wdata at the accept edge; reg_out updates the next cycle.
//   - Unmapped write is discarded. FSM stays IDLE; back-to-back writes allowed.
// - Read accept:
//   - Capture rd_q = mapped ? regs[idx] : '0 at the accept edge.
//   - Go to RLAT with lat_cnt=1. lat_cnt increments each cycle in RLAT.
//   - When lat_cnt==READ_LATENCY: rsp_valid=1, rsp_data=rd_q for exactly one cycle, then IDLE.
//   - READ_LATENCY=1: rsp_valid is high the cycle after accept.
// - Read data is the pre-write value: a read accepted in the same edge as a register update returns old contents.
// - rsp_data holds its last value after rsp_valid falls.
// - wvalid & rvalid both high (protocol violation): write is performed, read is ignored, no rsp_valid.
// - Single outstanding read: no new accept until rsp_valid has been issued. Next accept is possible in the
//   cycle after rsp_valid (REQ_WAIT=0).
// - Reset mid-read (in RLAT): the pending response is dropped, no rsp_valid, FSM=IDLE, regs cleared.
// CONFIGURATION
// - BUS_REG_ERR_EN defined:
//   - Adds output port rsp_err (1 bit), reset 0.
//   - Unmapped read: rsp_err=1 in the same cycle as rsp_valid.
//   - Unmapped write: rsp_err pulses 1 for one cycle, the cycle after accept.
//   - rsp_err=0 in all other cycles.
// - BUS_REG_ERR_EN undefined: rsp_err port does not exist; unmapped accesses are silently ignored / read 0.
// TESTING
// - Defaults: write addr 0x3 data 0xA5A5 -> ready high same cycle as wvalid; reg_out[3] = 0xA5A5 next cycle.
// - Defaults: read addr 0x3 -> ready same cycle; rsp_valid one cycle later with rsp_data=0xA5A5, single pulse.
// - REQ_WAIT=2, READ_LATENCY=3: read held 2 cycles -> ready on cycle 3; rsp_valid exactly 3 cycles after accept.
// - Read addr 0x0100 (unmapped) -> rsp_data=0x0000. With BUS_REG_ERR_EN: rsp_err=1 with rsp_valid.
//   Unmapped write -> no reg change.
// - READ_LATENCY=4: wvalid asserted during RLAT -> ready=0 until after rsp_valid, then write accepted; no request lost.
// - rst_n low 1 cycle during RLAT -> no rsp_valid; all reg_out=0; next read addr 0x3 returns 0x0000.

Source files
------------

// File: rtl/bus_reg_responder.sv
// bus_reg_responder: slave end of the VJTAG host system bus.
// Holds a bank of NUM_REGS read/write registers, exported flat on reg_out.
// REQ_WAIT adds request wait states; READ_LATENCY sets how long a read
// takes to answer, so slow peripherals can be modelled during bring-up.
// Optional build macro BUS_REG_ERR_EN adds an rsp_err output that flags
// accesses to unmapped addresses.
module bus_reg_responder #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_REGS     = 16,
  parameter int REQ_WAIT     = 0,
  parameter int READ_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          address,
  input  logic                           wvalid,
  input  logic                           rvalid,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic                           ready,
  output logic                           rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
`ifdef BUS_REG_ERR_EN
  output logic                           rsp_err,
`endif
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int WAIT_W = (REQ_WAIT > 0) ? $clog2(REQ_WAIT + 1) : 1;
  localparam int LAT_W  = $clog2(READ_LATENCY + 1);

  localparam logic [WAIT_W-1:0]     WAIT_MAX   = WAIT_W'(REQ_WAIT);
  localparam logic [LAT_W-1:0]      LAT_MAX    = LAT_W'(READ_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

  typedef enum logic {
    IDLE,
    RLAT
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] rsp_hold_q;
  logic                req;
  logic                mapped;
  logic [IDX_W-1:0]    idx;
  logic                wr_acc;
  logic                rd_acc;
  logic                rsp_fire;

  assign req    = wvalid | rvalid;
  assign mapped = (address < NUM_REGS_A);
  assign idx    = address[IDX_W-1:0];

  // Next-state, wait-state counting and accept decode; a write wins over a simultaneous read
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    wait_cnt_d = '0;
    ready      = 1'b0;
    wr_acc     = 1'b0;
    rd_acc     = 1'b0;
    rsp_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (wait_cnt_q == WAIT_MAX) begin
            ready  = rst_n;
            wr_acc = rst_n & wvalid;
            rd_acc = rst_n & rvalid & ~wvalid;
            if (rd_acc) begin
              state_d   = RLAT;
              lat_cnt_d = LAT_W'(1);
            end
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      RLAT: begin
        if (lat_cnt_q == LAT_MAX) begin
          rsp_fire  = rst_n;
          state_d   = IDLE;
          lat_cnt_d = '0;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      lat_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

  // Register bank; unmapped writes are dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_acc && mapped) begin
      regs[idx] <= wdata;
    end
  end

  // Capture read data at accept (pre-write contents) and remember the last response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q       <= '0;
      rsp_hold_q <= '0;
    end else begin
      if (rd_acc) begin
        rd_q <= mapped ? regs[idx] : '0;
      end
      if (rsp_fire) begin
        rsp_hold_q <= rd_q;
      end
    end
  end

  assign rsp_valid = rsp_fire;
  assign rsp_data  = rsp_fire ? rd_q : rsp_hold_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

`ifdef BUS_REG_ERR_EN
  logic rd_err_q;
  logic wr_err_q;

  // Remember whether the in-flight read missed the map, and pulse after an unmapped write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_err_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      if (rd_acc) begin
        rd_err_q <= ~mapped;
      end
      wr_err_q <= wr_acc & ~mapped;
    end
  end

  assign rsp_err = rst_n & ((rsp_fire & rd_err_q) | wr_err_q);
`endif

endmodule
